// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the main-memory port arbiter.
// Request bundle, FSM states and port indices.
package mem_port_arbiter_pkg;

   localparam int ARB_AW = 32;
   localparam int ARB_DW = 32;
   localparam int NPORT  = 3;

   localparam int PORT_RET_A = 0;
   localparam int PORT_RET_B = 1;
   localparam int PORT_FU    = 2;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      RESP
   } arbState;

   typedef struct packed {
      logic              valid;
      logic              we;
      logic [ARB_AW-1:0] addr;
      logic [ARB_DW-1:0] wdata;
   } memArbReq;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester and memory-side bus of the arbiter.
// slave = arbiter view, master = environment view.
interface mem_port_arbiter_if #(
   parameter int AW = 32,
   parameter int DW = 32
);
   logic [2:0]      req_valid;
   logic [2:0]      req_we;
   logic [3*AW-1:0] req_addr;
   logic [3*DW-1:0] req_wdata;
   logic [2:0]      req_ready;
   logic [2:0]      rsp_valid;
   logic [DW-1:0]   rsp_rdata;
   logic            rsp_err;
   logic            mem_req_valid;
   logic            mem_we;
   logic [AW-1:0]   mem_addr;
   logic [DW-1:0]   mem_wdata;
   logic            mem_rsp_valid;
   logic [DW-1:0]   mem_rdata;

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata,
      input  mem_rsp_valid, mem_rdata,
      output req_ready, rsp_valid, rsp_rdata, rsp_err,
      output mem_req_valid, mem_we, mem_addr, mem_wdata
   );

   modport master (
      output req_valid, req_we, req_addr, req_wdata,
      output mem_rsp_valid, mem_rdata,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err,
      input  mem_req_valid, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/mem_arb_prio_sel.sv
// Combinational winner select: port 0 > 1 > 2,
// with port 2 lifted to the top when promoted.
module mem_arb_prio_sel
   import mem_port_arbiter_pkg::*;
(
   input  logic [NPORT-1:0] req_valid,
   input  logic             promote,
   output logic [NPORT-1:0] grant
);

   // one-hot grant; slot a always ahead of slot b
   always_comb begin
      grant = '0;
      if (promote && req_valid[PORT_FU])
         grant[PORT_FU] = 1'b1;
      else if (req_valid[PORT_RET_A])
         grant[PORT_RET_A] = 1'b1;
      else if (req_valid[PORT_RET_B])
         grant[PORT_RET_B] = 1'b1;
      else if (req_valid[PORT_FU])
         grant[PORT_FU] = 1'b1;
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Three-port arbiter onto one single-ported memory.
// Optional macro MEM_ARB_STARVE_GUARD_EN: port 2 anti-starvation.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int AW           = ARB_AW,
   parameter int DW           = ARB_DW,
   parameter int TIMEOUT      = 16,
   parameter int STARVE_LIMIT = 4
)(
   input logic               clk,
   input logic               reset,
   mem_port_arbiter_if.slave bus
);

   localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   arbState          state_q, state_d;
   logic [NPORT-1:0] win_q, win_d;
   logic             we_q, we_d;
   memArbReq         mem_q, mem_d;
   logic [CW-1:0]    wcnt_q, wcnt_d;
   logic [NPORT-1:0] rsp_valid_q, rsp_valid_d;
   logic [DW-1:0]    rsp_rdata_q, rsp_rdata_d;
   logic             rsp_err_q, rsp_err_d;

   logic [NPORT-1:0] grant;
   logic [NPORT-1:0] accept;
   logic             promote;
   logic             sel_we;
   logic [AW-1:0]    sel_addr;
   logic [DW-1:0]    sel_wdata;

   mem_arb_prio_sel u_sel (
      .req_valid (bus.req_valid),
      .promote   (promote),
      .grant     (grant)
   );

   // grants only in IDLE, never while reset is held
   always_comb begin
      accept = '0;
      if (reset && state_q == IDLE)
         accept = grant;
   end

   // payload mux for the granted port
   always_comb begin
      sel_we    = 1'b0;
      sel_addr  = '0;
      sel_wdata = '0;
      for (int i = 0; i < NPORT; i++) begin
         if (grant[i]) begin
            sel_we    = bus.req_we[i];
            sel_addr  = bus.req_addr[i*AW +: AW];
            sel_wdata = bus.req_wdata[i*DW +: DW];
         end
      end
   end

`ifdef MEM_ARB_STARVE_GUARD_EN
   logic [2:0] starve_q, starve_d;

   // count lost IDLE arbitrations of port 2
   always_comb begin
      starve_d = starve_q;
      if (|accept) begin
         if (accept[PORT_FU])
            starve_d = '0;
         else if (bus.req_valid[PORT_FU] && starve_q != 3'd7)
            starve_d = starve_q + 3'd1;
      end
   end

   // starvation counter register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         starve_q <= '0;
      else
         starve_q <= starve_d;
   end

   assign promote = int'(starve_q) >= STARVE_LIMIT;
`else
   localparam int unused_starve_limit = STARVE_LIMIT;
   assign promote = 1'b0;
`endif

   // next-state and registered-output logic
   always_comb begin
      state_d     = state_q;
      win_d       = win_q;
      we_d        = we_q;
      mem_d       = mem_q;
      wcnt_d      = wcnt_q;
      rsp_valid_d = '0;
      rsp_rdata_d = '0;
      rsp_err_d   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (|accept) begin
               win_d       = accept;
               we_d        = sel_we;
               mem_d.valid = 1'b1;
               mem_d.we    = sel_we;
               mem_d.addr  = ARB_AW'(sel_addr);
               mem_d.wdata = ARB_DW'(sel_wdata);
               state_d     = ISSUE;
            end
         end
         ISSUE: begin
            mem_d   = '0;
            wcnt_d  = '0;
            state_d = WAIT;
         end
         WAIT: begin
            wcnt_d = wcnt_q + CW'(1);
            if (bus.mem_rsp_valid) begin
               rsp_valid_d = win_q;
               rsp_rdata_d = we_q ? '0 : bus.mem_rdata;
               state_d     = RESP;
            end else if (wcnt_q == CW'(TIMEOUT - 1)) begin
               rsp_valid_d = win_q;
               rsp_err_d   = 1'b1;
               state_d     = RESP;
            end
         end
         RESP: begin
            win_d   = '0;
            we_d    = 1'b0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // FSM, latches and registered outputs
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         win_q       <= '0;
         we_q        <= 1'b0;
         mem_q       <= '0;
         wcnt_q      <= '0;
         rsp_valid_q <= '0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         win_q       <= win_d;
         we_q        <= we_d;
         mem_q       <= mem_d;
         wcnt_q      <= wcnt_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
      end
   end

   assign bus.req_ready     = accept;
   assign bus.rsp_valid     = rsp_valid_q;
   assign bus.rsp_rdata     = rsp_rdata_q;
   assign bus.rsp_err       = rsp_err_q;
   assign bus.mem_req_valid = mem_q.valid;
   assign bus.mem_we        = mem_q.we;
   assign bus.mem_addr      = AW'(mem_q.addr);
   assign bus.mem_wdata     = DW'(mem_q.wdata);

endmodule
